unbuffer_8x8_axis_tx: RTL and testbench

- Reassembles an 8x8 pixel block arriving as 8 parallel lanes, one row per beat.
- Re-emits the block as a serial AXI4-Stream master, one pixel per beat, in row-major order.
- Sits at the back end of the preprocessing pipeline and returns processed blocks to DMA/stream fabric.
- Asserts TLAST on the 64th pixel and pulses an interrupt when the block is fully drained.

---
 rtl/unbuffer_8x8_axis_tx.sv | 151 +++++++++++++++
 tb/tb_unbuffer_8x8_axis_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/unbuffer_8x8_axis_tx.sv
// unbuffer_8x8_axis_tx
// Collects an 8x8 pixel block that arrives one row per beat on eight
// parallel lanes, then replays it as a serial AXI4-Stream, one pixel per
// beat in row-major order. TLAST marks pixel 63, and o_intr pulses for one
// cycle once the whole block has drained.
module unbuffer_8x8_axis_tx #(
    parameter int PIX_W   = 24,
    parameter int TDATA_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [PIX_W-1:0]   i_data1,
    input  logic [PIX_W-1:0]   i_data2,
    input  logic [PIX_W-1:0]   i_data3,
    input  logic [PIX_W-1:0]   i_data4,
    input  logic [PIX_W-1:0]   i_data5,
    input  logic [PIX_W-1:0]   i_data6,
    input  logic [PIX_W-1:0]   i_data7,
    input  logic [PIX_W-1:0]   i_data8,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [TDATA_W-1:0] m_axis_data,
    output logic               m_axis_valid,
    input  logic               m_axis_ready,
    output logic               m_axis_last,
    output logic               o_intr
);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [2:0]         wr_row_r;
    logic [5:0]         rd_idx_r;
    logic [5:0]         rd_nxt_s;
    logic [PIX_W-1:0]   buf_r [64];
    logic [PIX_W-1:0]   lanes_s [8];

    logic               row_acc_s;
    logic               last_row_s;
    logic               pix_acc_s;
    logic               last_pix_s;

    // Lane k carries column k of the current row.
    assign lanes_s[0] = i_data1;
    assign lanes_s[1] = i_data2;
    assign lanes_s[2] = i_data3;
    assign lanes_s[3] = i_data4;
    assign lanes_s[4] = i_data5;
    assign lanes_s[5] = i_data6;
    assign lanes_s[6] = i_data7;
    assign lanes_s[7] = i_data8;

    // Input side is open for the whole FILL phase, including while in reset.
    assign o_ready    = (state_r == ST_FILL);
    assign row_acc_s  = i_valid && o_ready;
    assign last_row_s = row_acc_s && (wr_row_r == 3'd7);
    assign pix_acc_s  = (state_r == ST_DRAIN) && m_axis_valid && m_axis_ready;
    assign last_pix_s = pix_acc_s && (rd_idx_r == 6'd63);
    assign rd_nxt_s   = rd_idx_r + 6'd1;

    // Next-state logic: a full block flips to DRAIN, the final beat flips back.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (last_row_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (last_pix_s) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            default: begin
                state_nxt_s = ST_FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_r <= ST_FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Row write pointer; wraps from 7 to 0 on the row that completes a block.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            wr_row_r <= 3'd0;
        end else if (row_acc_s) begin
            wr_row_r <= wr_row_r + 3'd1;
        end else begin
            wr_row_r <= wr_row_r;
        end
    end

    // Pixel store: one full row written per accepted beat; never cleared.
    always_ff @(posedge i_clk) begin
        if (i_rst && row_acc_s) begin
            for (int k = 0; k < 8; k++) begin
                buf_r[{wr_row_r, 3'(k)}] <= lanes_s[k];
            end
        end
    end

    // Stream output registers. Pixel 0 is loaded on the edge that accepts
    // row 7; row 0 was written on an earlier edge, and rows 7's pixels are
    // only fetched 56+ beats later, so no read can overtake its write.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            m_axis_data  <= {TDATA_W{1'b0}};
            o_intr       <= 1'b0;
            rd_idx_r     <= 6'd0;
        end else begin
            o_intr <= 1'b0;
            if (last_row_s) begin
                m_axis_valid <= 1'b1;
                m_axis_last  <= 1'b0;
                m_axis_data  <= TDATA_W'(buf_r[0]);
                rd_idx_r     <= 6'd0;
            end else if (last_pix_s) begin
                m_axis_valid <= 1'b0;
                m_axis_last  <= 1'b0;
                o_intr       <= 1'b1;
                rd_idx_r     <= 6'd0;
            end else if (pix_acc_s) begin
                rd_idx_r     <= rd_nxt_s;
                m_axis_data  <= TDATA_W'(buf_r[rd_nxt_s]);
                m_axis_last  <= (rd_nxt_s == 6'd63);
            end else begin
                // Stalled or idle: hold everything stable.
                rd_idx_r     <= rd_idx_r;
            end
        end
    end

endmodule

// File: tb/tb_unbuffer_8x8_axis_tx.sv
// Self-checking bench for unbuffer_8x8_axis_tx. The reference is simply the
// block as a flat 64-entry array in row-major order: every stream beat must
// match the next entry, with tlast only on entry 63.
module tb_unbuffer_8x8_axis_tx;
    localparam int PIX_W   = 24;
    localparam int TDATA_W = 32;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic [PIX_W-1:0]   lane [8];
    logic               i_valid;
    logic               o_ready;
    logic [TDATA_W-1:0] m_axis_data;
    logic               m_axis_valid;
    logic               m_axis_ready;
    logic               m_axis_last;
    logic               o_intr;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int intr_cyc = 0;
    logic [PIX_W-1:0] blk [64];

    always #5 i_clk = ~i_clk;

    unbuffer_8x8_axis_tx #(.PIX_W(PIX_W), .TDATA_W(TDATA_W)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_data1      (lane[0]),
        .i_data2      (lane[1]),
        .i_data3      (lane[2]),
        .i_data4      (lane[3]),
        .i_data5      (lane[4]),
        .i_data6      (lane[5]),
        .i_data7      (lane[6]),
        .i_data8      (lane[7]),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last),
        .o_intr       (o_intr)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
        cyc++;
    endtask

    // Reference block: either pixel(r,c) = 0x0000rc or random RGB values.
    task automatic fill_pattern(input bit rnd);
        for (int i = 0; i < 64; i++) begin
            if (rnd) blk[i] = PIX_W'($urandom);
            else     blk[i] = PIX_W'((i / 8) * 16 + (i % 8));
        end
    endtask

    // Present nrows rows with gap idle cycles between rows (none after the last).
    task automatic send_rows(input int nrows, input int gap);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < 8; c++) lane[c] = blk[r * 8 + c];
            i_valid = 1'b1;
            check_val("fill_ready", o_ready, 1);
            check_val("fill_no_valid", m_axis_valid, 0);
            tick();
            i_valid = 1'b0;
            if (r < nrows - 1) begin
                for (int g = 0; g < gap; g++) begin
                    check_val("gap_no_valid", m_axis_valid, 0);
                    tick();
                end
            end
        end
    endtask

    // Consume the stream against blk[]. Stops early after stop_after beats
    // (leaving the DUT mid-drain) when stop_after is in 0..63.
    task automatic drain_block(input bit rnd_ready, input bit flood, input int stop_after);
        int n = 0;
        int cycles = 0;
        bit stall = 1'b0;
        logic [TDATA_W-1:0] pd = '0;
        logic pl = 1'b0;
        check_val("drain_valid_rise", m_axis_valid, 1);
        while (n < 64 && cycles < 2000 && n != stop_after) begin
            m_axis_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (flood) begin
                i_valid = 1'b1;
                for (int c = 0; c < 8; c++) lane[c] = {PIX_W{1'b1}};
            end
            check_val("drain_no_ready", o_ready, 0);
            check_val("drain_no_intr", o_intr, 0);
            if (stall) begin
                check_val("stall_valid", m_axis_valid, 1);
                check_val("stall_data", m_axis_data, pd);
                check_val("stall_last", m_axis_last, pl);
            end
            stall = m_axis_valid && !m_axis_ready;
            pd = m_axis_data;
            pl = m_axis_last;
            if (m_axis_valid && m_axis_ready) begin
                check_val("beat_data", m_axis_data, TDATA_W'(blk[n]));
                check_val("beat_last", m_axis_last, (n == 63) ? 64'd1 : 64'd0);
                n++;
            end
            tick();
            cycles++;
        end
        i_valid = 1'b0;
        if (n != stop_after) begin
            check_val("beats", n, 64);
            if (!rnd_ready) check_val("drain_cycles", cycles, 64);
            check_val("done_intr", o_intr, 1);
            check_val("done_valid", m_axis_valid, 0);
            check_val("done_last", m_axis_last, 0);
            check_val("done_ready", o_ready, 1);
            intr_cyc = cyc;
        end
    endtask

    initial begin
        int c1;
        i_rst = 1'b0;
        i_valid = 1'b0;
        m_axis_ready = 1'b0;
        for (int c = 0; c < 8; c++) lane[c] = '0;
        repeat (3) tick();
        check_val("rst_ready", o_ready, 1);
        check_val("rst_valid", m_axis_valid, 0);
        check_val("rst_last", m_axis_last, 0);
        check_val("rst_data", m_axis_data, 0);
        check_val("rst_intr", o_intr, 0);
        i_rst = 1'b1;
        tick();

        // Basic block: 8 fill + 64 drain, then the one-cycle interrupt.
        fill_pattern(1'b0);
        send_rows(8, 0);
        drain_block(1'b0, 1'b0, -1);
        tick();
        check_val("intr_one_cycle", o_intr, 0);
        check_val("idle_valid", m_axis_valid, 0);

        // Backpressure with random data and random ready.
        fill_pattern(1'b1);
        send_rows(8, 0);
        drain_block(1'b1, 1'b0, -1);
        tick();
        check_val("bp_single_intr", o_intr, 0);

        // Input blocking: all-ones rows pushed throughout the drain.
        fill_pattern(1'b1);
        send_rows(8, 0);
        drain_block(1'b1, 1'b1, -1);
        // Next block must start at row 0 again (and not contain the flood).
        fill_pattern(1'b1);
        send_rows(8, 0);
        drain_block(1'b0, 1'b0, -1);
        tick();

        // Gapped fill reproduces the basic sequence.
        fill_pattern(1'b0);
        send_rows(8, 3);
        drain_block(1'b0, 1'b0, -1);
        tick();

        // Reset mid-fill discards partial rows.
        fill_pattern(1'b1);
        send_rows(3, 0);
        i_rst = 1'b0;
        tick();
        i_rst = 1'b1;
        tick();
        fill_pattern(1'b1);
        send_rows(8, 0);
        drain_block(1'b0, 1'b0, -1);
        tick();

        // Reset after 20 drain beats abandons the block silently.
        fill_pattern(1'b1);
        send_rows(8, 0);
        drain_block(1'b0, 1'b0, 20);
        i_rst = 1'b0;
        m_axis_ready = 1'b1;
        tick();
        check_val("mrst_valid", m_axis_valid, 0);
        check_val("mrst_last", m_axis_last, 0);
        check_val("mrst_intr", o_intr, 0);
        check_val("mrst_ready", o_ready, 1);
        i_rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("mrst_no_intr", o_intr, 0);
            check_val("mrst_no_valid", m_axis_valid, 0);
        end
        fill_pattern(1'b1);
        send_rows(8, 0);
        drain_block(1'b0, 1'b0, -1);

        // Back-to-back: next row 0 goes in on the interrupt cycle. Pulses land
        // 72 clocks apart, i.e. spanning 73 cycles counted inclusively.
        fill_pattern(1'b1);
        send_rows(8, 0);
        drain_block(1'b0, 1'b0, -1);
        c1 = intr_cyc;
        fill_pattern(1'b0);
        send_rows(8, 0);
        drain_block(1'b0, 1'b0, -1);
        check_val("b2b_intr_spacing", intr_cyc - c1, 72);
        tick();
        check_val("b2b_intr_one_cycle", o_intr, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
